// File: rtl/dram_axi_bridge.sv
// dram_axi_bridge
//   Turns core word reads / masked word writes into single-beat AXI4
//   transactions toward the MIG. Writes are posted through a small FIFO.
//   Reads wait for every queued and in-flight write to complete, which
//   gives read-after-write ordering.
// Ports
//   clk, rst_x          : clock, async active-low reset
//   i_rd_en/i_wr_en     : core requests (write wins when both are high)
//   i_addr/i_data/i_mask: byte address, write word, byte enables
//   o_busy              : request not accepted this cycle
//   o_data/o_data_valid : read beat (held) and its one-cycle valid pulse
//   o_rerr/o_werr       : read error (with valid), sticky write error
//   s_axi_*             : AXI4 master toward the MIG
module dram_axi_bridge #(
  parameter int          ADDR_WIDTH = 28,
  parameter int          DATA_WIDTH = 128,
  parameter int          WQ_DEPTH   = 4,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    i_rd_en,
  input  logic                    i_wr_en,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_data,
  input  logic [3:0]              i_mask,
  output logic                    o_busy,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_data_valid,
  output logic                    o_rerr,
  output logic                    o_werr,
  output logic [3:0]              s_axi_awid,
  output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  output logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  output logic [7:0]              s_axi_awlen,
  output logic [2:0]              s_axi_awsize,
  output logic [1:0]              s_axi_awburst,
  output logic                    s_axi_awlock,
  output logic [3:0]              s_axi_awcache,
  output logic [2:0]              s_axi_awprot,
  output logic [3:0]              s_axi_awqos,
  output logic [DATA_WIDTH-1:0]   s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                    s_axi_wlast,
  output logic                    s_axi_wvalid,
  input  logic                    s_axi_wready,
  input  logic [3:0]              s_axi_bid,
  input  logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_bvalid,
  output logic                    s_axi_bready,
  output logic [3:0]              s_axi_arid,
  output logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                    s_axi_arvalid,
  input  logic                    s_axi_arready,
  output logic [7:0]              s_axi_arlen,
  output logic [2:0]              s_axi_arsize,
  output logic [1:0]              s_axi_arburst,
  output logic                    s_axi_arlock,
  output logic [3:0]              s_axi_arcache,
  output logic [2:0]              s_axi_arprot,
  output logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_rid,
  input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
  input  logic [1:0]              s_axi_rresp,
  input  logic                    s_axi_rlast,
  input  logic                    s_axi_rvalid,
  output logic                    s_axi_rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int LANES  = DATA_WIDTH / 32;
  localparam int PW     = $clog2(WQ_DEPTH);
  localparam int CW     = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_AR, ST_R} state_e;

  // Queue storage needs no reset: occupancy is tracked by wq_cnt_q.
  logic [ADDR_WIDTH-1:0] q_addr_mem [WQ_DEPTH];
  logic [31:0]           q_data_mem [WQ_DEPTH];
  logic [STRB_W-1:0]     q_strb_mem [WQ_DEPTH];

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         wq_cnt_q, wq_cnt_d, ob_cnt_q, ob_cnt_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_dv_q, o_dv_d, o_rerr_q, o_rerr_d, o_werr_q, o_werr_d;

  logic                  wq_full, wq_empty, issue_ok, aw_hs, w_hs, b_hs, pop;
  logic                  wr_acc, rd_acc, rd_cap;
  logic [31:0]           lane_w;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic [STRB_W-1:0]     strb_in;

  assign wq_full  = (wq_cnt_q == CW'(WQ_DEPTH));
  assign wq_empty = (wq_cnt_q == '0);
  assign o_busy   = wq_full | (state_q != ST_IDLE);
  assign wr_acc   = i_wr_en & ~o_busy;
  assign rd_acc   = i_rd_en & ~i_wr_en & ~o_busy;

  // Steering: align to the beat and shift the 4-bit mask to its word lane.
  assign lane_w  = (i_addr >> 2) & 32'(LANES - 1);
  assign addr_al = i_addr[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(STRB_W - 1);
  assign strb_in = STRB_W'(i_mask) << {lane_w[29:0], 2'b00};

  // Head issues only while the B window has room; each channel drops its
  // valid once its own handshake is done and waits for the joint pop.
  assign issue_ok = ~wq_empty & (ob_cnt_q != CW'(WQ_DEPTH));
  assign s_axi_awvalid = issue_ok & ~aw_done_q;
  assign s_axi_wvalid  = issue_ok & ~w_done_q;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign pop   = issue_ok & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign b_hs  = s_axi_bvalid & bready_q;

  assign s_axi_awaddr = q_addr_mem[rd_ptr_q];
  assign s_axi_wdata  = {LANES{q_data_mem[rd_ptr_q]}};
  assign s_axi_wstrb  = q_strb_mem[rd_ptr_q];
  assign s_axi_wlast  = 1'b1;
  assign s_axi_bready = bready_q;

  assign s_axi_awid    = AXI_ID;
  assign s_axi_awlen   = 8'd0;
  assign s_axi_awsize  = 3'(LSB);
  assign s_axi_awburst = 2'b01;
  assign s_axi_awlock  = 1'b0;
  assign s_axi_awcache = 4'b0011;
  assign s_axi_awprot  = 3'd0;
  assign s_axi_awqos   = 4'd0;
  assign s_axi_arid    = AXI_ID;
  assign s_axi_arlen   = 8'd0;
  assign s_axi_arsize  = 3'(LSB);
  assign s_axi_arburst = 2'b01;
  assign s_axi_arlock  = 1'b0;
  assign s_axi_arcache = 4'b0011;
  assign s_axi_arprot  = 3'd0;
  assign s_axi_arqos   = 4'd0;

  assign s_axi_araddr  = rd_addr_q;
  assign s_axi_arvalid = (state_q == ST_AR);
  assign s_axi_rready  = (state_q == ST_R);
  assign rd_cap        = (state_q == ST_R) & s_axi_rvalid;

  assign o_data       = o_data_q;
  assign o_data_valid = o_dv_q;
  assign o_rerr       = o_rerr_q;
  assign o_werr       = o_werr_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi_bid, s_axi_rid, s_axi_rlast, i_addr};

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    wq_cnt_d  = wq_cnt_q + CW'(wr_acc) - CW'(pop);
    aw_done_d = pop ? 1'b0 : (aw_done_q | aw_hs);
    w_done_d  = pop ? 1'b0 : (w_done_q | w_hs);
    ob_cnt_d  = ob_cnt_q;
    if (pop && !b_hs)                           ob_cnt_d = ob_cnt_q + 1'b1;
    else if (!pop && b_hs && ob_cnt_q != '0)    ob_cnt_d = ob_cnt_q - 1'b1;
    o_werr_d  = o_werr_q | (b_hs & (s_axi_bresp != 2'b00));
    rd_addr_d = rd_acc ? addr_al : rd_addr_q;
    o_data_d  = rd_cap ? s_axi_rdata : o_data_q;
    o_dv_d    = rd_cap;
    o_rerr_d  = rd_cap & (s_axi_rresp != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rd_acc) state_d = ST_DRAIN;
      // Empty queue and zero outstanding B means every earlier write landed.
      ST_DRAIN: if (wq_empty && ob_cnt_q == '0) state_d = ST_AR;
      ST_AR:    if (s_axi_arready) state_d = ST_R;
      ST_R:     if (s_axi_rvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      q_addr_mem[wr_ptr_q] <= addr_al;
      q_data_mem[wr_ptr_q] <= i_data;
      q_strb_mem[wr_ptr_q] <= strb_in;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wq_cnt_q  <= '0;
      ob_cnt_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      rd_addr_q <= '0;
      o_data_q  <= '0;
      o_dv_q    <= 1'b0;
      o_rerr_q  <= 1'b0;
      o_werr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wq_cnt_q  <= wq_cnt_d;
      ob_cnt_q  <= ob_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= 1'b1;
      rd_addr_q <= rd_addr_d;
      o_data_q  <= o_data_d;
      o_dv_q    <= o_dv_d;
      o_rerr_q  <= o_rerr_d;
      o_werr_q  <= o_werr_d;
    end
  end
endmodule

// File: doc/dram_axi_bridge.md
# dram_axi_bridge

Single-clock successor to the DRAM front-end: converts core-side word reads and masked word writes into single-beat AXI4 transactions toward the MIG at a parametrised data width. Adds a posted-write queue of configurable depth, multiple outstanding write responses, read-after-write ordering, and AXI error reporting. Sits between the core's memory port and the MIG AXI slave. Both sides run on `clk`, so the block contains no clock-domain crossing.

## Interface
Parameters:
- ADDR_WIDTH, 28, AXI byte-address width.
- DATA_WIDTH, 128, AXI data width. Power of two, at least 32.
- WQ_DEPTH, 4, posted-write queue entries and the maximum number of outstanding B responses. Power of two, at least 2.
- AXI_ID, 0, constant 4-bit ID driven on `awid` and `arid`.

Ports:
- clk  in  1  the only clock.
- rst_x  in  1  reset, asynchronous, active-low.
- i_rd_en  in  1  read request.
- i_wr_en  in  1  write request.
- i_addr  in  32  byte address. Bits [1:0] are ignored.
- i_data  in  32  write data.
- i_mask  in  4  byte enables. 1 = write that byte.
- o_busy  out  1  high when a request will not be accepted this cycle.
- o_data  out  DATA_WIDTH  full read beat.
- o_data_valid  out  1  one-cycle pulse marking a read result.
- o_rerr  out  1  rresp != 0 for the current read. Valid together with o_data_valid.
- o_werr  out  1  sticky. Set on any bresp != 0. Cleared only by reset.
- s_axi_awid/awaddr/awvalid  out  4/ADDR_WIDTH/1  write address channel.
- s_axi_awready  in  1  write address ready.
- s_axi_awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  8/3/2/1/4/3/4  tied to 0 / log2(DATA_WIDTH/8) / INCR / 0 / 4'b0011 / 0 / 0. The same tie-offs apply to the ar* equivalents.
- s_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel. `wlast` is always 1.
- s_axi_wready  in  1  write data ready.
- s_axi_bid/bresp/bvalid  in  4/2/1  write response. `bid` is ignored.
- s_axi_bready  out  1  write response ready. Always 1 after reset.
- s_axi_arid/araddr/arvalid  out  4/ADDR_WIDTH/1  read address channel.
- s_axi_arready  in  1  read address ready.
- s_axi_rid/rdata/rresp/rlast/rvalid  in  4/DATA_WIDTH/2/1/1  read data channel. `rid` and `rlast` are ignored.
- s_axi_rready  out  1  read data ready.

## Operation
- **Request acceptance.** A request is accepted on a rising edge where (i_rd_en | i_wr_en) & !o_busy.
  - If both enables are high, the write is accepted and the read is ignored. The core re-presents the read.
  - o_busy = wq_full | (state != IDLE).
- **Write queue.** The write queue is a FIFO of {addr, data, mask} entries.
  - Writes are posted: the block accepts a write into the queue without waiting for DRAM.
  - The head entry drives AW and W at the same time. The two handshakes complete independently.
  - The entry is popped once both handshakes have completed, which may happen in the same cycle or in different cycles. After its handshake completes, each valid stays low until the next pop.
  - The queue does not issue when the outstanding-B counter equals WQ_DEPTH.
- **Outstanding-B counter.**
  - The counter is $clog2(WQ_DEPTH)+1 bits wide.
  - It increments on a pop and decrements on bvalid.
  - If a pop and bvalid happen in the same cycle, the count is unchanged.
- **Lane steering.** Let LSB = log2(DATA_WIDTH/8).
  - Address: awaddr/araddr = {i_addr[ADDR_WIDTH-1:LSB], LSB'b0}.
  - Write data: wdata = i_data replicated DATA_WIDTH/32 times.
  - Write strobes: wstrb = i_mask << (4·i_addr[LSB-1:2]).
- **Read state machine.**
  - IDLE: on an accepted read, latch the address and go to DRAIN.
  - DRAIN: wait until the queue is empty and the outstanding count is 0, which guarantees read-after-write ordering. Then go to AR with arvalid = 1.
  - AR: on arready, clear arvalid and go to R with rready = 1.
  - R: on rvalid, register rdata into o_data and rresp != 0 into o_rerr. Pulse o_data_valid and return to IDLE.
- **Read data retention.** o_data holds its value until the next read completes.
- **Writes during a read.** The core cannot enqueue writes while a read is in progress (o_busy is high), so DRAIN cannot be starved.

## Timing
- **Reset values.** All valids are 0, and rready, o_data, o_data_valid, o_rerr and o_werr are 0. The queue is empty, the counter is 0 and the state is IDLE. bready rises one cycle after rst_x deasserts.
- **Write accepted at edge N.** awvalid and wvalid are high after edge N if the queue was empty and the outstanding count is below WQ_DEPTH.
- **Read accepted at edge N with nothing pending.** DRAIN is entered at N, arvalid goes high at N+1, and rready goes high at the edge where arready is sampled. With zero-wait responses, the R beat is captured at N+3 and o_data_valid is high for the cycle after N+3.
- **Full queue.** o_busy is high in the same cycle the last slot fills. A pop in that cycle does not unblock acceptance until the next cycle, because o_busy is computed from the registered count.
- **Outstanding limit.** With WQ_DEPTH outstanding responses, AW and W stay low until a bvalid arrives.
- **Reset mid-transaction.** All outputs return immediately to their reset values. The slave must also be reset; the block does not attempt to complete an AXI transaction that was interrupted by reset.

## Test plan
- **Single write.** Write addr 0x104, data 0xDEADBEEF, mask 4'b0011 with DATA_WIDTH=128.
  - Expect awaddr 0x100.
  - Expect wstrb 16'h0030.
  - Expect wdata to be 0xDEADBEEF replicated ×4.
  - Expect exactly one AW handshake and one W handshake.
- **Queue full and back-pressure.** Hold awready = 0 and issue 5 writes with WQ_DEPTH=4.
  - Expect o_busy to rise after the 4th write is accepted.
  - The 5th write is accepted only after the first pop.
  - Writes reach DRAM in submission order.
- **Skewed handshakes.** Drive wready 3 cycles before awready.
  - Expect exactly one pop, occurring after both handshakes.
  - wvalid stays low between the W handshake and the pop.
- **Read-after-write.** Write to 0x200, then immediately read 0x200, with bvalid delayed 10 cycles.
  - arvalid must not rise until the cycle after bvalid.
  - o_data equals the returned rdata.
  - o_data_valid is a single-cycle pulse.
- **Error reporting.** Return bresp = 2'b10 on one write and rresp = 2'b11 on one read.
  - o_werr is set and stays set.
  - o_rerr is 1 only together with that read's o_data_valid.
- **Simultaneous enables and reset mid-read.**
  - With i_rd_en and i_wr_en both high: only the write is queued.
  - Assert rst_x low while in the R state: all valids, rready, o_data_valid and o_busy drop to 0 immediately.
